// File: rtl/hwpe_ctrl_uloop_sequencer.sv
// Steps the uloop one iteration at a time and turns its offsets into per-stream address requests.
// start->uloop clear 1 cycle, step 2 cycles; each iteration waits for every enabled stream ack before stepping again.
module hwpe_ctrl_uloop_sequencer #(
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NB_STREAMS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned SEL_WIDTH = (NB_REG > 1) ? $clog2(NB_REG) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             start_i,
  input  logic [NB_STREAMS-1:0]            stream_en_i,
  input  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [NB_STREAMS*SEL_WIDTH-1:0]  offs_sel_i,
  output logic                             uloop_clear_o,
  output logic                             uloop_enable_o,
  input  logic                             uloop_valid_i,
  input  logic                             uloop_done_i,
  input  logic [NB_REG*REG_WIDTH-1:0]      uloop_offs_i,
  output logic [NB_STREAMS-1:0]            stream_req_o,
  output logic [NB_STREAMS*ADDR_WIDTH-1:0] stream_addr_o,
  input  logic [NB_STREAMS-1:0]            stream_ack_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [CNT_WIDTH-1:0]             iter_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STEP,
    WAIT,
    ISSUE
  } state_e;

  state_e                          state_q;
  logic [NB_STREAMS-1:0]           en_q;
  logic [NB_STREAMS-1:0]           pending_q;
  logic [NB_STREAMS-1:0]           pending_nxt;
  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_q;
  logic [NB_STREAMS*ADDR_WIDTH-1:0] addr_q;
  logic [NB_STREAMS*ADDR_WIDTH-1:0] addr_nxt;
  logic [NB_STREAMS*SEL_WIDTH-1:0]  sel_q;
  logic                            last_q;
  logic [CNT_WIDTH-1:0]            cnt_q;

  // Out-of-range selects fall back to offset register 0, so it is the default.
  always_comb begin
    addr_nxt = '0;
    for (int s = 0; s < NB_STREAMS; s++) begin
      addr_nxt[s*ADDR_WIDTH +: ADDR_WIDTH] = base_q[s*ADDR_WIDTH +: ADDR_WIDTH]
                                           + ADDR_WIDTH'(uloop_offs_i[0 +: REG_WIDTH]);
      for (int r = 1; r < NB_REG; r++) begin
        if (sel_q[s*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(r)) begin
          addr_nxt[s*ADDR_WIDTH +: ADDR_WIDTH] = base_q[s*ADDR_WIDTH +: ADDR_WIDTH]
                                               + ADDR_WIDTH'(uloop_offs_i[r*REG_WIDTH +: REG_WIDTH]);
        end
      end
    end
  end

  assign pending_nxt = pending_q & ~stream_ack_i;

  // Completion is flagged in the cycle the last ack lands, while the FSM is still busy.
  assign done_o = (state_q == ISSUE) && last_q && (pending_nxt == '0) && !clear_i;

  assign stream_req_o  = pending_q;
  assign stream_addr_o = addr_q;
  assign busy_o        = (state_q != IDLE);
  assign iter_cnt_o    = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      en_q           <= '0;
      pending_q      <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      sel_q          <= '0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
      uloop_clear_o  <= 1'b0;
      uloop_enable_o <= 1'b0;
    end else if (clear_i) begin
      state_q        <= IDLE;
      en_q           <= '0;
      pending_q      <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      sel_q          <= '0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
      uloop_clear_o  <= 1'b0;
      uloop_enable_o <= 1'b0;
    end else begin
      uloop_clear_o  <= 1'b0;
      uloop_enable_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            en_q          <= stream_en_i;
            base_q        <= base_addr_i;
            sel_q         <= offs_sel_i;
            cnt_q         <= '0;
            uloop_clear_o <= 1'b1;
            state_q       <= CLR;
          end
        end
        CLR: begin
          uloop_enable_o <= 1'b1;
          state_q        <= STEP;
        end
        STEP: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (uloop_valid_i) begin
            last_q    <= uloop_done_i;
            addr_q    <= addr_nxt;
            pending_q <= en_q;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          pending_q <= pending_nxt;
          if (pending_nxt == '0) begin
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (last_q) begin
              state_q <= IDLE;
            end else begin
              uloop_enable_o <= 1'b1;
              state_q        <= STEP;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
